// File: rtl/down_timer.sv
// Loadable down-counting timer: counts LOAD_VALUE down on ENABLE ticks and
// pulses TRIG_OUT once on expiry. Define DOWN_TIMER_AUTO_RELOAD_EN for periodic reload.
module down_timer #(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   LOAD,
  input  logic [COUNT_WIDTH-1:0] LOAD_VALUE,
  input  logic                   ABORT,
  output logic [COUNT_WIDTH-1:0] COUNT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   TRIG_OUT,
  output logic [1:0]             STATE_DBG
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  logic [1:0]             state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] reload_q;
  logic                   trig_q;

  // Priority each edge: ABORT > LOAD > ENABLE. TRIG_OUT defaults low so it
  // can only ever be a single-cycle pulse.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      trig_q   <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (ABORT) begin
        state_q <= ST_IDLE;
        count_q <= '0;
      end else if (LOAD) begin
        reload_q <= LOAD_VALUE;
        if (LOAD_VALUE != '0) begin
          count_q <= LOAD_VALUE;
          state_q <= ST_RUN;
        end else begin
          count_q <= '0;
          state_q <= ST_EXPIRED;
          trig_q  <= 1'b1;
        end
      end else if (state_q == ST_RUN && ENABLE) begin
        if (count_q > 1) begin
          count_q <= count_q - 1'b1;
        end else begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          count_q <= reload_q;
          trig_q  <= 1'b1;
`else
          count_q <= '0;
          state_q <= ST_EXPIRED;
          trig_q  <= 1'b1;
`endif
        end
      end
    end
  end

  assign COUNT     = count_q;
  assign BUSY      = (state_q == ST_RUN);
  assign DONE      = (state_q == ST_EXPIRED);
  assign TRIG_OUT  = trig_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: vector table plus hand-written
// sequences for reset, max load and (when enabled) auto-reload.
module tb_down_timer;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         trig_out;
  logic [1:0]   state_dbg;

  // Expected word layout: {COUNT, BUSY, DONE, TRIG_OUT}
  logic [W+2:0] exp_q[$];
  int checks;
  int failures;

  typedef struct {
    logic         ab;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic [W+2:0] exp;
  } vec_t;

  down_timer #(.COUNT_WIDTH(W)) dut (
    .CLK        (clk),
    .RESET      (rst_n),
    .ENABLE     (enable),
    .LOAD       (load),
    .LOAD_VALUE (load_value),
    .ABORT      (abort),
    .COUNT      (count),
    .BUSY       (busy),
    .DONE       (done),
    .TRIG_OUT   (trig_out),
    .STATE_DBG  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b trig=%0b, want count=%0d busy=%0b done=%0b trig=%0b",
               name, act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Driver: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
  task automatic step(input string name, input logic ab, input logic ld, input logic [W-1:0] lv,
                      input logic en, input logic [W+2:0] exp);
    logic [W+2:0] e;
    @(negedge clk);
    abort = ab; load = ld; load_value = lv; enable = en;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(name, {count, busy, done, trig_out}, e);
  endtask

  vec_t vecs[25];

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = '0; abort = 1'b0;

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
    //            ab    ld    lv     en    {count, busy, done, trig}
    vecs[0]  = '{1'b0, 1'b1, 4'd3,  1'b0, {4'd3, 3'b100}};
    vecs[1]  = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd2, 3'b100}};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd1, 3'b100}};
    vecs[3]  = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd0, 3'b011}};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd0, 3'b010}};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd0, 3'b010}};
    vecs[6]  = '{1'b0, 1'b1, 4'd2,  1'b0, {4'd2, 3'b100}};
    vecs[7]  = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd2, 3'b100}};
    vecs[8]  = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd2, 3'b100}};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd2, 3'b100}};
    vecs[10] = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd1, 3'b100}};
    vecs[11] = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd1, 3'b100}};
    vecs[12] = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd1, 3'b100}};
    vecs[13] = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd1, 3'b100}};
    vecs[14] = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd0, 3'b011}};
    vecs[15] = '{1'b0, 1'b0, 4'd0,  1'b0, {4'd0, 3'b010}};
    vecs[16] = '{1'b0, 1'b1, 4'd2,  1'b0, {4'd2, 3'b100}};
    vecs[17] = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd1, 3'b100}};
    vecs[18] = '{1'b0, 1'b1, 4'd7,  1'b1, {4'd7, 3'b100}};
    vecs[19] = '{1'b1, 1'b1, 4'd5,  1'b0, {4'd0, 3'b000}};
    vecs[20] = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd0, 3'b000}};
    vecs[21] = '{1'b0, 1'b1, 4'd0,  1'b0, {4'd0, 3'b011}};
    vecs[22] = '{1'b0, 1'b0, 4'd0,  1'b1, {4'd0, 3'b010}};
    vecs[23] = '{1'b0, 1'b1, 4'd0,  1'b0, {4'd0, 3'b011}};
    vecs[24] = '{1'b1, 1'b0, 4'd0,  1'b0, {4'd0, 3'b000}};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {count, busy, done, trig_out}, {4'd0, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;

`ifndef DOWN_TIMER_AUTO_RELOAD_EN
    for (int i = 0; i < 25; i++) begin
      step($sformatf("vec%0d", i), vecs[i].ab, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].exp);
    end

    // Max load: 15 ENABLEs to expiry, then no underflow
    step("max_load", 1'b0, 1'b1, 4'd15, 1'b0, {4'd15, 3'b100});
    for (int i = 14; i >= 1; i--) begin
      logic [W-1:0] c;
      c = i[W-1:0];
      step("max_dec", 1'b0, 1'b0, 4'd0, 1'b1, {c, 3'b100});
    end
    step("max_expire", 1'b0, 1'b0, 4'd0, 1'b1, {4'd0, 3'b011});
    step("max_hold", 1'b0, 1'b0, 4'd0, 1'b1, {4'd0, 3'b010});
`else
    // Auto-reload: LOAD 4 then 12 ENABLEs -> pulses on the 4th, 8th and 12th
    step("ar_load", 1'b0, 1'b1, 4'd4, 1'b0, {4'd4, 3'b100});
    for (int k = 1; k <= 12; k++) begin
      logic [W-1:0] c;
      logic t;
      t = (k % 4 == 0);
      c = (k % 4 == 0) ? 4'd4 : 4'(4 - (k % 4));
      step($sformatf("ar_en%0d", k), 1'b0, 1'b0, 4'd0, 1'b1, {c, 1'b1, 1'b0, t});
    end
    step("ar_abort", 1'b1, 1'b0, 4'd0, 1'b1, {4'd0, 3'b000});
    step("ar_zero_load", 1'b0, 1'b1, 4'd0, 1'b0, {4'd0, 3'b011});
    step("ar_expired_hold", 1'b0, 1'b0, 4'd0, 1'b1, {4'd0, 3'b010});
`endif

    // Asynchronous reset mid-countdown at COUNT=5
    step("rst_load", 1'b0, 1'b1, 4'd9, 1'b0, {4'd9, 3'b100});
    for (int i = 8; i >= 5; i--) begin
      logic [W-1:0] c;
      c = i[W-1:0];
      step("rst_dec", 1'b0, 1'b0, 4'd0, 1'b1, {c, 3'b100});
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {count, busy, done, trig_out}, {4'd0, 3'b000});
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_idle", 1'b0, 1'b0, 4'd0, 1'b1, {4'd0, 3'b000});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
